// File: rtl/msg_schedule.sv
// SHA-256 message schedule feeder.
//
// Accepts one 512-bit padded block over a valid/ready handshake. It then issues the 64 schedule
// words W[t] from a 16-word sliding window, together with the round constants K[t] and an advance
// strobe for the compression registers.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   blk_valid  upstream block available on blk_data
//   blk_data   message block, W[0] in [511:480], W[15] in [31:0]
//   blk_ready  block can be accepted this cycle (registered)
//   stall_i    downstream hold; freezes round progression
//   w_o        current schedule word W[t] (0 outside RUN)
//   k_o        current round constant K[t] (0 outside RUN)
//   round_o    current round index t (0 outside RUN)
//   sel_o      1 = compression consumes w_o/k_o on this edge
//   start_o    one-cycle pulse on block acceptance
//   done_o     one-cycle pulse after the last round is consumed
module msg_schedule #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  input  logic [511:0] blk_data,
  output logic         blk_ready,
  input  logic         stall_i,
  output logic [31:0]  w_o,
  output logic [31:0]  k_o,
  output logic [5:0]   round_o,
  output logic         sel_o,
  output logic         start_o,
  output logic         done_o
);

  localparam logic [5:0] LastRound = 6'(ROUNDS - 1);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [31:0] window_q [16];
  logic [5:0]  round_q;
  logic        blk_ready_q;
  logic        start_q;
  logic        done_q;

  logic        run;
  logic        accept;
  logic [31:0] w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  always_comb begin
    run    = (state_q == StRun);
    accept = (state_q == StIdle) && blk_valid && blk_ready_q;
    // Computed unconditionally; words past W[63] are never consumed.
    w_new  = sig1(window_q[14]) + window_q[9] + sig0(window_q[1]) + window_q[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      round_q     <= '0;
      blk_ready_q <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < 16; i++) window_q[i] <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            for (int i = 0; i < 16; i++) window_q[i] <= blk_data[511 - 32*i -: 32];
            round_q     <= '0;
            blk_ready_q <= 1'b0;
            start_q     <= 1'b1;
            state_q     <= StRun;
          end else begin
            blk_ready_q <= 1'b1;
          end
        end
        StRun: begin
          if (!stall_i) begin
            for (int i = 0; i < 15; i++) window_q[i] <= window_q[i+1];
            window_q[15] <= w_new;
            round_q      <= round_q + 6'd1;
            if (round_q == LastRound) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          blk_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    blk_ready = blk_ready_q;
    start_o   = start_q;
    done_o    = done_q;
    sel_o     = run && !stall_i;
    w_o       = run ? window_q[0] : '0;
    k_o       = run ? K[round_q] : '0;
    round_o   = run ? round_q : '0;
  end

endmodule

// File: doc/msg_schedule.md
Name: msg_schedule

Overview:
Upstream feeder for the round/compression datapath. It accepts one 512-bit padded message block through a valid/ready handshake and expands it into the 64 SHA-256 schedule words W[0..63] using a 16-word sliding window. Each round it presents W[t] and K[t] together with an advance strobe (`sel_o`) that drives the compression register's `sel` input. It flags block start and block completion so the downstream stage can initialise its working variables and capture the hash.

Parameters:
ROUNDS, 64, number of schedule words issued per block (fixed at 64 for SHA-256; other values unsupported)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
blk_valid  input  1  upstream has a block on blk_data
blk_data  input  512  message block, big-endian word order; W[0] = blk_data[511:480], W[15] = blk_data[31:0]
blk_ready  output  1  block can be accepted this cycle
stall_i  input  1  downstream hold request; freezes round progression
w_o  output  32  current schedule word W[t]
k_o  output  32  current round constant K[t]
round_o  output  6  current round index t
sel_o  output  1  advance strobe to compression registers; 1 = consume w_o/k_o this edge
start_o  output  1  one-cycle pulse on block acceptance
done_o  output  1  one-cycle pulse after round 63 is consumed

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; window, round counter and all registered outputs cleared.
  - blk_ready=0, start_o=0, done_o=0, sel_o=0, round_o=0, w_o=0, k_o=0.
- blk_ready is registered. It is set on the first rising edge after reset release, and is 1 throughout IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Accept when blk_valid && blk_ready at a rising edge.
  - On accept: load window[0..15] from blk_data, round<=0, blk_ready<=0, start_o<=1 for one cycle, go to RUN.
  - blk_valid with blk_ready=0 is ignored; blk_data is don't-care then.
- RUN:
  - w_o = window[0] and k_o = K[round], both combinational from registers.
  - K is a 64-entry constant ROM using the FIPS 180-4 values.
  - sel_o = !stall_i (combinational).
  - stall_i=1: window and round hold; sel_o=0.
  - stall_i=0, each edge:
    - window shifts down: window[i] <= window[i+1] for i=0..14.
    - window[15] <= sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], mod 2^32.
    - round increments.
  - sigma0(x) = ror7 ^ ror18 ^ shr3; sigma1(x) = ror17 ^ ror19 ^ shr10.
  - The new word is computed every cycle, including after round 47. Words produced beyond W[63] are never consumed and are harmless.
  - On a non-stalled edge with round==63: go to DONE, done_o<=1.
  - Exactly 64 cycles with sel_o=1 per block.
- DONE (one cycle):
  - done_o=1, sel_o=0, w_o=0, k_o=0.
  - Next edge: blk_ready<=1, go to IDLE.
  - A block offered during DONE is not accepted until IDLE.
- Outside RUN: sel_o=0, w_o=0, k_o=0, round_o=0.
- round_o equals the round counter in RUN; it never wraps within a block.
- stall_i in IDLE/DONE: no effect.
- Reset asserted mid-RUN: immediate return to IDLE values. No done_o pulse; the partial block is discarded.
- Throughput: 66 cycles per block with no stalls (1 accept + 64 RUN + 1 DONE), plus stall cycles.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release → all outputs 0; blk_ready=1 one edge after release.
- "abc" block (W0=0x61626380, W15=0x00000018, others 0), stall_i=0:
  - start_o pulses.
  - Round 0: w_o=0x61626380, k_o=0x428a2f98.
  - Round 16: w_o=0x61626380, k_o=0xe49b69c1.
  - Round 17: w_o=0x000f0000.
  - Round 63: k_o=0xc67178f2.
  - Count of sel_o=1 cycles is 64; done_o pulses on the next cycle.
- Stall: assert stall_i for 5 cycles at round 20 → sel_o=0, w_o/round_o frozen; done_o delayed by exactly 5 cycles.
- Back-to-back: blk_valid held high with two blocks → second accepted on the first IDLE edge after DONE; 66-cycle spacing between start_o pulses.
- Reset at round 30 → outputs return to 0 asynchronously; no done_o; blk_ready returns to 1 after release.
- Full vector: feed the "abc" block into msg_schedule plus the compression stage → hash = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
